// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester A/B request-response channels and the single-port memory channel.
// Handshake: a request transfers on the rising edge where req_valid && req_ready; ready is
// combinational and may depend on valid. Responses are one-cycle pulses with no backpressure.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int BSEL_W = DATA_W / 8;

  logic              a_req_valid;
  logic              a_req_ready;
  logic              a_req_we;
  logic [ADDR_W-1:0] a_req_addr;
  logic [DATA_W-1:0] a_req_wdata;
  logic [BSEL_W-1:0] a_req_bsel;
  logic              a_rsp_valid;
  logic [DATA_W-1:0] a_rsp_data;
  logic              a_rsp_err;

  logic              b_req_valid;
  logic              b_req_ready;
  logic              b_req_we;
  logic [ADDR_W-1:0] b_req_addr;
  logic [DATA_W-1:0] b_req_wdata;
  logic [BSEL_W-1:0] b_req_bsel;
  logic              b_rsp_valid;
  logic [DATA_W-1:0] b_rsp_data;
  logic              b_rsp_err;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BSEL_W-1:0] mem_wr_bsel;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              mem_wr_ack;

  modport master (
    input  a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_bsel,
    output a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
    input  b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_bsel,
    output b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_bsel,
    input  mem_rd_data, mem_rd_valid, mem_wr_ack
  );

  modport slave (
    output a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_bsel,
    input  a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
    output b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_bsel,
    input  b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_bsel,
    output mem_rd_data, mem_rd_valid, mem_wr_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between requesters A and B,
// one transaction in flight, registered per-port responses and a response timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      arst,
  mem_port_arbiter_if.master        bus,
  output logic [1:0]                dbg_state
);
  localparam int         BSEL_W      = DATA_W / 8;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic       PORT_A      = 1'b0;
  localparam logic       PORT_B      = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BSEL_W-1:0] bsel_q, bsel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              a_rsp_valid_q, a_rsp_valid_d, a_rsp_err_q, a_rsp_err_d;
  logic              b_rsp_valid_q, b_rsp_valid_d, b_rsp_err_q, b_rsp_err_d;
  logic [DATA_W-1:0] a_rsp_data_q, a_rsp_data_d, b_rsp_data_q, b_rsp_data_d;

  logic any_valid;
  logic pick_b;
  logic done;

  // On a tie the port that was not served last wins.
  assign any_valid = bus.a_req_valid | bus.b_req_valid;
  assign pick_b    = bus.b_req_valid & (~bus.a_req_valid | (last_grant_q == PORT_A));
  // Only the completion kind matching the in-flight transaction counts.
  assign done      = we_q ? bus.mem_wr_ack : bus.mem_rd_valid;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    bsel_d        = bsel_q;
    cnt_d         = cnt_q;
    a_rsp_valid_d = 1'b0;
    a_rsp_err_d   = 1'b0;
    a_rsp_data_d  = '0;
    b_rsp_valid_d = 1'b0;
    b_rsp_err_d   = 1'b0;
    b_rsp_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_d = pick_b;
          we_d    = pick_b ? bus.b_req_we    : bus.a_req_we;
          addr_d  = pick_b ? bus.b_req_addr  : bus.a_req_addr;
          wdata_d = pick_b ? bus.b_req_wdata : bus.a_req_wdata;
          bsel_d  = pick_b ? bus.b_req_bsel  : bus.a_req_bsel;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done || (cnt_q == TIMEOUT_CNT)) begin
          if (grant_q == PORT_B) begin
            b_rsp_valid_d = 1'b1;
            b_rsp_err_d   = ~done;
            b_rsp_data_d  = (done && !we_q) ? bus.mem_rd_data : '0;
          end else begin
            a_rsp_valid_d = 1'b1;
            a_rsp_err_d   = ~done;
            a_rsp_data_d  = (done && !we_q) ? bus.mem_rd_data : '0;
          end
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= PORT_B;
      grant_q       <= PORT_A;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bsel_q        <= '0;
      cnt_q         <= '0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_err_q   <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_err_q   <= 1'b0;
      b_rsp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      bsel_q        <= bsel_d;
      cnt_q         <= cnt_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_err_q   <= a_rsp_err_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_err_q   <= b_rsp_err_d;
      b_rsp_data_q  <= b_rsp_data_d;
    end
  end

  assign bus.a_req_ready = (state_q == S_IDLE) & bus.a_req_valid & ~pick_b;
  assign bus.b_req_ready = (state_q == S_IDLE) & pick_b;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.a_rsp_err   = a_rsp_err_q;
  assign bus.a_rsp_data  = a_rsp_data_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.b_rsp_err   = b_rsp_err_q;
  assign bus.b_rsp_data  = b_rsp_data_q;

  // Enables are decoded from state so an async reset drops them immediately.
  assign bus.mem_rd_en   = (state_q == S_ISSUE) & ~we_q;
  assign bus.mem_wr_en   = (state_q == S_ISSUE) & we_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.mem_wr_addr = addr_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.mem_wr_bsel = bsel_q;

  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       arst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         mem_mode = 0;  // 0 normal, 1 never answers, 2 wrong-kind ack before rd_valid
  int         late_req = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 9) return 32'h0;
    return 32'h1357_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  initial begin : mem_model
    logic [31:0] mem_arr [256];
    logic        rd_p, wr_p, dly_rd;
    logic [7:0]  ra, dly_addr;
    int          late_done;
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    bus.mem_rd_valid = 1'b0;
    bus.mem_wr_ack   = 1'b0;
    bus.mem_rd_data  = '0;
    dly_rd = 1'b0;
    dly_addr = '0;
    late_done = 0;
    forever begin
      @(negedge clk);
      rd_p = (mem_mode != 1) && bus.mem_rd_en;
      wr_p = (mem_mode != 1) && bus.mem_wr_en;
      ra   = bus.mem_rd_addr;
      if (wr_p) mem_arr[bus.mem_wr_addr] = merge(mem_arr[bus.mem_wr_addr], bus.mem_wr_data,
                                                 bus.mem_wr_bsel);
      @(posedge clk);
      #1;
      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_ack   = 1'b0;
      bus.mem_rd_data  = $urandom;
      if (dly_rd) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem_arr[dly_addr];
        dly_rd = 1'b0;
      end
      if (rd_p) begin
        if (mem_mode == 2) begin
          bus.mem_wr_ack = 1'b1;
          dly_rd = 1'b1;
          dly_addr = ra;
        end else begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = mem_arr[ra];
        end
      end
      if (wr_p) bus.mem_wr_ack = 1'b1;
      if (late_req != late_done) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_wr_ack   = 1'b1;
        late_done++;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin : compare
    logic [31:0] ref_mem [256];
    int          n, m_acc, m_due, w;
    bit          m_busy, m_res, m_last, m_port, m_we, m_err;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_data;
    logic [3:0]  m_bsel;
    logic        ea_v, eb_v, ea_e, eb_e;
    logic [31:0] ea_d, eb_d;
    bit          ok;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    n = 0; m_busy = 0; m_res = 0; m_last = 1; m_due = -1; m_acc = 0;
    m_port = 0; m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_bsel = '0; m_data = '0;
    forever begin
      @(negedge clk);
      n++;
      if (arst) begin
        m_busy = 0; m_res = 0; m_last = 1; m_due = -1;
        check("rst_a_rsp_valid", bus.a_rsp_valid, 0);
        check("rst_b_rsp_valid", bus.b_rsp_valid, 0);
        check("rst_a_rsp_data", bus.a_rsp_data, 0);
        check("rst_rd_en", bus.mem_rd_en, 0);
        check("rst_wr_en", bus.mem_wr_en, 0);
        check("rst_rd_addr", bus.mem_rd_addr, 0);
        check("rst_wr_bsel", bus.mem_wr_bsel, 0);
        check("rst_state", dbg_state, 0);
        continue;
      end
      ea_v = 0; eb_v = 0; ea_e = 0; eb_e = 0; ea_d = '0; eb_d = '0;
      if (m_busy && m_res && n == m_due) begin
        if (m_port) begin eb_v = 1; eb_e = m_err; eb_d = m_data; end
        else        begin ea_v = 1; ea_e = m_err; ea_d = m_data; end
        if (m_we && !m_err) ref_mem[m_addr] = merge(ref_mem[m_addr], m_wdata, m_bsel);
        m_last = m_port;
        m_busy = 0;
      end
      check("a_rsp_valid", bus.a_rsp_valid, ea_v);
      check("a_rsp_err", bus.a_rsp_err, ea_e);
      check("a_rsp_data", bus.a_rsp_data, ea_d);
      check("b_rsp_valid", bus.b_rsp_valid, eb_v);
      check("b_rsp_err", bus.b_rsp_err, eb_e);
      check("b_rsp_data", bus.b_rsp_data, eb_d);

      check("mem_rd_en", bus.mem_rd_en, m_busy && (n - m_acc == 1) && !m_we);
      check("mem_wr_en", bus.mem_wr_en, m_busy && (n - m_acc == 1) && m_we);
      if (m_busy && (n - m_acc == 1)) begin
        if (m_we) begin
          check("mem_wr_addr", bus.mem_wr_addr, m_addr);
          check("mem_wr_data", bus.mem_wr_data, m_wdata);
          check("mem_wr_bsel", bus.mem_wr_bsel, m_bsel);
        end else begin
          check("mem_rd_addr", bus.mem_rd_addr, m_addr);
        end
      end

      w = -1;
      if (!m_busy) begin
        if (bus.a_req_valid && bus.b_req_valid) w = m_last ? 0 : 1;
        else if (bus.a_req_valid) w = 0;
        else if (bus.b_req_valid) w = 1;
      end
      check("a_req_ready", bus.a_req_ready, w == 0);
      check("b_req_ready", bus.b_req_ready, w == 1);

      if (w >= 0) begin
        m_port  = (w == 1);
        m_we    = m_port ? bus.b_req_we    : bus.a_req_we;
        m_addr  = m_port ? bus.b_req_addr  : bus.a_req_addr;
        m_wdata = m_port ? bus.b_req_wdata : bus.a_req_wdata;
        m_bsel  = m_port ? bus.b_req_bsel  : bus.a_req_bsel;
        m_busy = 1; m_res = 0; m_acc = n;
      end else if (m_busy && !m_res && (n - m_acc >= 2)) begin
        ok = m_we ? bus.mem_wr_ack : bus.mem_rd_valid;
        if (ok) begin
          m_res = 1; m_due = n + 1; m_err = 0;
          m_data = m_we ? 32'h0 : ref_mem[m_addr];
        end else if (n - m_acc == TIMEOUT + 2) begin
          m_res = 1; m_due = n + 1; m_err = 1; m_data = 32'h0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input bit port, input bit we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] bsel);
    bit accepted;
    @(posedge clk);
    #1;
    if (port) begin
      bus.b_req_we = we; bus.b_req_addr = addr; bus.b_req_wdata = wdata;
      bus.b_req_bsel = bsel; bus.b_req_valid = 1'b1;
    end else begin
      bus.a_req_we = we; bus.a_req_addr = addr; bus.a_req_wdata = wdata;
      bus.a_req_bsel = bsel; bus.a_req_valid = 1'b1;
    end
    accepted = 0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = port ? bus.b_req_ready : bus.a_req_ready;
    end
    check(port ? "b_accept" : "a_accept", accepted, 1);
    @(posedge clk);
    #1;
    if (port) begin
      bus.b_req_valid = 1'b0; bus.b_req_we = 1'($urandom); bus.b_req_addr = 8'($urandom);
      bus.b_req_wdata = $urandom; bus.b_req_bsel = 4'($urandom);
    end else begin
      bus.a_req_valid = 1'b0; bus.a_req_we = 1'($urandom); bus.a_req_addr = 8'($urandom);
      bus.a_req_wdata = $urandom; bus.a_req_bsel = 4'($urandom);
    end
  endtask

  // lat counts negedges since acceptance; first sampled negedge is number 'first'.
  task automatic wait_rsp(input bit port, input int first, output int lat,
                          output logic [31:0] d, output logic e);
    lat = -1; d = '0; e = 1'b0;
    for (int k = first; k < first + 100; k++) begin
      @(negedge clk);
      if (port ? bus.b_rsp_valid : bus.a_rsp_valid) begin
        lat = k;
        d = port ? bus.b_rsp_data : bus.a_rsp_data;
        e = port ? bus.b_rsp_err : bus.a_rsp_err;
        break;
      end
    end
  endtask

  task automatic rand_port(input bit port);
    repeat (30) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      do_req(port, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          lat, ra, rb, pulses;
    logic [31:0] d;
    logic        e;
    bit          both;
    int          grants[$];
    arst = 1'b1;
    bus.a_req_valid = 0; bus.a_req_we = 0; bus.a_req_addr = '0; bus.a_req_wdata = '0;
    bus.a_req_bsel = '0;
    bus.b_req_valid = 0; bus.b_req_we = 0; bus.b_req_addr = '0; bus.b_req_wdata = '0;
    bus.b_req_bsel = '0;
    repeat (3) @(posedge clk);
    #3 arst = 1'b0;

    // single read
    do_req(0, 0, 8'd5, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_rd_en", bus.mem_rd_en, 1);
    check("t1_rd_addr", bus.mem_rd_addr, 5);
    wait_rsp(0, 2, lat, d, e);
    check("t1_lat", 64'(lat), 3);
    check("t1_data", d, 32'hDEADBEEF);
    check("t1_err", e, 0);

    // byte write then read back
    do_req(1, 1, 8'd9, 32'h11223344, 4'b0101);
    @(negedge clk);
    check("t2_wr_en", bus.mem_wr_en, 1);
    check("t2_wr_bsel", bus.mem_wr_bsel, 4'b0101);
    wait_rsp(1, 2, lat, d, e);
    check("t2_lat", 64'(lat), 3);
    check("t2_data", d, 0);
    do_req(0, 0, 8'd9, 32'h0, 4'h0);
    wait_rsp(0, 1, lat, d, e);
    check("t2_readback", d, 32'h00220044);

    // wrong-kind ack first, right one a cycle later
    mem_mode = 2;
    do_req(0, 0, 8'd5, 32'h0, 4'h0);
    wait_rsp(0, 1, lat, d, e);
    check("t6_lat", 64'(lat), 4);
    check("t6_data", d, 32'hDEADBEEF);
    check("t6_err", e, 0);

    // timeout, then a stale ack that must be ignored
    mem_mode = 1;
    do_req(0, 0, 8'd7, 32'h0, 4'h0);
    wait_rsp(0, 1, lat, d, e);
    check("t4_lat", 64'(lat), TIMEOUT + 3);
    check("t4_err", e, 1);
    check("t4_data", d, 0);
    late_req++;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(bus.a_rsp_valid) + int'(bus.b_rsp_valid);
    end
    check("t4_stale_pulses", 64'(pulses), 0);

    // async reset while a write waits
    do_req(0, 1, 8'd200, 32'hCAFEF00D, 4'hF);
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    check("t5_state", dbg_state, 0);
    check("t5_wr_en", bus.mem_wr_en, 0);
    check("t5_wr_addr", bus.mem_wr_addr, 0);
    check("t5_a_rsp", bus.a_rsp_valid, 0);
    mem_mode = 0;
    repeat (2) @(posedge clk);
    #3 arst = 1'b0;

    // contention from reset: A first, then strict alternation
    @(posedge clk);
    #1;
    bus.a_req_we = 0; bus.a_req_addr = 8'd1; bus.a_req_valid = 1;
    bus.b_req_we = 0; bus.b_req_addr = 8'd2; bus.b_req_valid = 1;
    ra = 0; rb = 0; both = 0;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      if (k <= 23 && bus.a_req_ready) grants.push_back(0);
      if (k <= 23 && bus.b_req_ready) grants.push_back(1);
      if (bus.a_req_ready && bus.b_req_ready) both = 1;
      if (k >= 1) begin
        ra += int'(bus.a_rsp_valid);
        rb += int'(bus.b_rsp_valid);
      end
    end
    @(posedge clk);
    #1;
    bus.a_req_valid = 0; bus.b_req_valid = 0;
    check("t3_grant_count", 64'(grants.size()), 8);
    foreach (grants[i]) check("t3_grant_order", 64'(grants[i]), 64'(i % 2));
    check("t3_a_rsps", 64'(ra), 4);
    check("t3_b_rsps", 64'(rb), 4);
    check("t3_both_ready", both, 0);
    repeat (8) @(posedge clk);

    // randomized traffic from both ports
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (30) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
